ppd_commutator_sync: RTL and testbench

Fully synchronous input commutator for polyphase decimation filters. It distributes a serial sample stream across M polyphase lanes and presents one parallel M-lane frame per M accepted samples. M is runtime-selectable up to GP_MAX_DECIM. Handshakes are valid/ready on both sides, with no derived clocks. It sits between the sample source and the polyphase subfilter bank.

---
 rtl/ppd_pkg.sv | 29 ++
 rtl/ppd_lane_sequencer.sv | 92 +++++++++
 rtl/ppd_commutator_sync.sv | 120 ++++++++++++
 tb/tb_ppd_commutator_sync.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ppd_pkg.sv
// Shared types and helpers for the polyphase commutator: lane-order state, decimation clamp, lane slicing.
package ppd_pkg;

   typedef enum logic {S_SKIP, S_FILL} state_t;

   localparam int PPD_DFLT_MAX_DECIM = 8;

   function automatic int ppd_idx_w(input int max_d);
      return (max_d > 2) ? $clog2(max_d) : 1;
   endfunction

   function automatic int ppd_cnt_w(input int max_d);
      return $clog2(max_d + 1);
   endfunction

   localparam int PPD_DFLT_IDX_W = ppd_idx_w(PPD_DFLT_MAX_DECIM);
   localparam int PPD_DFLT_CW    = ppd_cnt_w(PPD_DFLT_MAX_DECIM);

   function automatic int clamp_decim(input int d, input int max_d);
      if (d < 2)     return 2;
      if (d > max_d) return max_d;
      return d;
   endfunction

   function automatic int lane_lsb(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/ppd_lane_sequencer.sv
// Phase skip, lane index walk and per-frame decimation latch; no datapath. Combinational flags, 0-cycle.
// Optional o_cfg_bad with PPD_COMMUTATOR_STATUS_EN: pulses when a sampled decimation needed clamping.
module ppd_lane_sequencer
   import ppd_pkg::*;
#(
   parameter int GP_MAX_DECIM = PPD_DFLT_MAX_DECIM,
   parameter int GP_CCW       = 1,
   parameter int GP_PHASE     = 0,
   localparam int CW          = ppd_cnt_w(GP_MAX_DECIM),
   localparam int IW          = ppd_idx_w(GP_MAX_DECIM)
) (
   input  logic          i_clk,
   input  logic          i_rst_an,
   input  logic          i_clr,
   input  logic [CW-1:0] i_decim,
   input  logic          i_accept,
   output logic          o_fill,
   output logic          o_last,
   output logic [IW-1:0] o_lane,
   output logic [CW-1:0] o_m_act
`ifdef PPD_COMMUTATOR_STATUS_EN
   ,
   output logic          o_cfg_bad
`endif
);

   localparam state_t        ST_INIT = (GP_PHASE > 0) ? S_SKIP : S_FILL;
   localparam logic [CW-1:0] PH      = CW'(GP_PHASE);
   localparam logic [CW-1:0] MAXV    = CW'(GP_MAX_DECIM);
   localparam logic [CW-1:0] ONE     = CW'(1);

   state_t        state, state_nxt;
   logic [CW-1:0] skip_cnt, skip_nxt;
   logic [CW-1:0] pos, pos_nxt;
   logic [CW-1:0] m_act, m_nxt;
   logic [CW-1:0] m_clamp, m_eff;
   logic          boundary;

   assign m_clamp  = CW'(clamp_decim(int'(i_decim), GP_MAX_DECIM));
   assign boundary = (state == S_FILL) && (pos == '0);
   // The first sample of a frame already uses the freshly sampled M for its lane
   assign m_eff    = boundary ? m_clamp : m_act;
   assign o_fill   = (state == S_FILL);
   assign o_last   = (state == S_FILL) && (pos == m_act - ONE);
   assign o_lane   = (GP_CCW != 0) ? IW'(pos) : IW'(m_eff - ONE - pos);
   assign o_m_act  = m_act;

`ifdef PPD_COMMUTATOR_STATUS_EN
   assign o_cfg_bad = (i_clr || (i_accept && boundary)) &&
                      ((int'(i_decim) < 2) || (int'(i_decim) > GP_MAX_DECIM));
`endif

   always_comb begin
      state_nxt = state;
      skip_nxt  = skip_cnt;
      pos_nxt   = pos;
      m_nxt     = m_act;
      if (i_clr) begin
         state_nxt = ST_INIT;
         skip_nxt  = PH;
         pos_nxt   = '0;
         m_nxt     = m_clamp;
      end else if (i_accept) begin
         case (state)
            S_SKIP: begin
               skip_nxt = skip_cnt - ONE;
               if (skip_cnt == ONE) state_nxt = S_FILL;
            end
            S_FILL: begin
               if (boundary) m_nxt = m_clamp;
               pos_nxt = o_last ? '0 : pos + ONE;
            end
            default: state_nxt = ST_INIT;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an) begin
         state    <= ST_INIT;
         skip_cnt <= PH;
         pos      <= '0;
         m_act    <= MAXV;
      end else begin
         state    <= state_nxt;
         skip_cnt <= skip_nxt;
         pos      <= pos_nxt;
         m_act    <= m_nxt;
      end
   end

endmodule

// File: rtl/ppd_commutator_sync.sv
// Serial-to-M-lane commutator: frame valid 1 cycle after last accept; o_ready drops only when the last lane would overwrite an unaccepted frame.
// Optional status outputs (frame count, clamp error) with PPD_COMMUTATOR_STATUS_EN.
module ppd_commutator_sync
   import ppd_pkg::*;
#(
   parameter int GP_DATA_WIDTH = 16,
   parameter int GP_MAX_DECIM  = PPD_DFLT_MAX_DECIM,
   parameter int GP_CCW        = 1,
   parameter int GP_PHASE      = 0,
   localparam int CW           = ppd_cnt_w(GP_MAX_DECIM)
) (
   input  logic                                   i_clk,
   input  logic                                   i_rst_an,
   input  logic                                   i_clr,
   input  logic [CW-1:0]                          i_decim,
   input  logic                                   i_valid,
   output logic                                   o_ready,
   input  logic signed [GP_DATA_WIDTH-1:0]        i_data,
   output logic                                   o_valid,
   input  logic                                   i_ready,
   output logic [GP_MAX_DECIM*GP_DATA_WIDTH-1:0]  o_data,
   output logic                                   o_clk
`ifdef PPD_COMMUTATOR_STATUS_EN
   ,
   output logic [15:0]                            o_frame_cnt,
   output logic                                   o_cfg_err
`endif
);

   localparam int W  = GP_DATA_WIDTH;
   localparam int IW = ppd_idx_w(GP_MAX_DECIM);

   logic                          accept, load, fill, last;
   logic [IW-1:0]                 lane;
   logic [CW-1:0]                 m_act;
   logic signed [W-1:0]           bank [GP_MAX_DECIM];
   logic [GP_MAX_DECIM*W-1:0]     frame;
`ifdef PPD_COMMUTATOR_STATUS_EN
   logic                          cfg_bad;
`endif

   ppd_lane_sequencer #(
      .GP_MAX_DECIM (GP_MAX_DECIM),
      .GP_CCW       (GP_CCW),
      .GP_PHASE     (GP_PHASE)
   ) u_seq (
      .i_clk    (i_clk),
      .i_rst_an (i_rst_an),
      .i_clr    (i_clr),
      .i_decim  (i_decim),
      .i_accept (accept),
      .o_fill   (fill),
      .o_last   (last),
      .o_lane   (lane),
      .o_m_act  (m_act)
`ifdef PPD_COMMUTATOR_STATUS_EN
      ,
      .o_cfg_bad(cfg_bad)
`endif
   );

   assign o_ready = !(last && o_valid && !i_ready);
   assign accept  = i_valid && o_ready;
   assign load    = accept && last;

   // Final sample bypasses the bank; lanes beyond the active M read as zero
   always_comb begin
      frame = '0;
      for (int k = 0; k < GP_MAX_DECIM; k++) begin
         if (k < int'(m_act))
            frame[lane_lsb(k, W) +: W] = (k == int'(lane)) ? i_data : bank[k];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an) begin
         for (int k = 0; k < GP_MAX_DECIM; k++) bank[k] <= '0;
      end else if (i_clr) begin
         for (int k = 0; k < GP_MAX_DECIM; k++) bank[k] <= '0;
      end else if (accept && fill) begin
         bank[lane] <= i_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an) begin
         o_valid <= 1'b0;
         o_clk   <= 1'b0;
         o_data  <= '0;
      end else if (i_clr) begin
         o_valid <= 1'b0;
         o_clk   <= 1'b0;
         o_data  <= '0;
      end else begin
         o_clk <= load;
         if (load) begin
            o_data  <= frame;
            o_valid <= 1'b1;
         end else if (i_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

`ifdef PPD_COMMUTATOR_STATUS_EN
   always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an) begin
         o_frame_cnt <= '0;
         o_cfg_err   <= 1'b0;
      end else if (i_clr) begin
         o_frame_cnt <= '0;
         o_cfg_err   <= cfg_bad;
      end else begin
         if (load)    o_frame_cnt <= o_frame_cnt + 16'd1;
         if (cfg_bad) o_cfg_err   <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_ppd_commutator_sync.sv
// Directed bench: three instances (CCW up, CCW down, phase 2) share stimulus; vector table plus hand sequences.
module tb_ppd_commutator_sync;

   logic               clk    = 1'b0;
   logic               rst_an = 1'b0;
   logic               clr    = 1'b0;
   logic               vld    = 1'b0;
   logic               rdy    = 1'b1;
   logic [3:0]         decim  = 4'd4;
   logic signed [15:0] din    = '0;

   logic [2:0]         rdy_o, vld_o, clk_o;
   logic [2:0][127:0]  dat_o;
`ifdef PPD_COMMUTATOR_STATUS_EN
   logic [2:0][15:0]   fcnt_o;
   logic [2:0]         err_o;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ppd_commutator_sync #(.GP_DATA_WIDTH(16), .GP_MAX_DECIM(8), .GP_CCW(1), .GP_PHASE(0)) dut0 (
      .i_clk(clk), .i_rst_an(rst_an), .i_clr(clr), .i_decim(decim), .i_valid(vld),
      .o_ready(rdy_o[0]), .i_data(din), .o_valid(vld_o[0]), .i_ready(rdy),
      .o_data(dat_o[0]), .o_clk(clk_o[0])
`ifdef PPD_COMMUTATOR_STATUS_EN
      , .o_frame_cnt(fcnt_o[0]), .o_cfg_err(err_o[0])
`endif
   );

   ppd_commutator_sync #(.GP_DATA_WIDTH(16), .GP_MAX_DECIM(8), .GP_CCW(0), .GP_PHASE(0)) dut1 (
      .i_clk(clk), .i_rst_an(rst_an), .i_clr(clr), .i_decim(decim), .i_valid(vld),
      .o_ready(rdy_o[1]), .i_data(din), .o_valid(vld_o[1]), .i_ready(rdy),
      .o_data(dat_o[1]), .o_clk(clk_o[1])
`ifdef PPD_COMMUTATOR_STATUS_EN
      , .o_frame_cnt(fcnt_o[1]), .o_cfg_err(err_o[1])
`endif
   );

   ppd_commutator_sync #(.GP_DATA_WIDTH(16), .GP_MAX_DECIM(8), .GP_CCW(1), .GP_PHASE(2)) dut2 (
      .i_clk(clk), .i_rst_an(rst_an), .i_clr(clr), .i_decim(decim), .i_valid(vld),
      .o_ready(rdy_o[2]), .i_data(din), .o_valid(vld_o[2]), .i_ready(rdy),
      .o_data(dat_o[2]), .o_clk(clk_o[2])
`ifdef PPD_COMMUTATOR_STATUS_EN
      , .o_frame_cnt(fcnt_o[2]), .o_cfg_err(err_o[2])
`endif
   );

   typedef struct {
      int           sel;
      bit           chk;
      bit           clr, vld, rdy;
      logic [3:0]   decim;
      logic [15:0]  din;
      bit           ev, ec, er;
      logic [127:0] ed;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [127:0] fr(input logic [15:0] l0, l1, l2, l3, l4, l5, l6, l7);
      return {l7, l6, l5, l4, l3, l2, l1, l0};
   endfunction

   task automatic add(input int sel, input bit chk, input bit c, input bit v, input bit r,
                      input logic [3:0] d, input logic [15:0] x,
                      input bit ev, input bit ec, input bit er, input logic [127:0] ed);
      vec_t t;
      t.sel = sel; t.chk = chk; t.clr = c; t.vld = v; t.rdy = r; t.decim = d; t.din = x;
      t.ev = ev; t.ec = ec; t.er = er; t.ed = ed;
      tbl.push_back(t);
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step(input bit c, input bit v, input bit r, input logic [3:0] d, input logic [15:0] x);
      @(negedge clk);
      clr = c; vld = v; rdy = r; decim = d; din = x;
      #1;
   endtask

   task automatic chk_out(input string tag, input int s, input bit ev, input bit ec, input bit er,
                          input logic [127:0] ed);
      chk({tag, "_valid"}, 128'(vld_o[s]), 128'(ev));
      chk({tag, "_oclk"},  128'(clk_o[s]), 128'(ec));
      chk({tag, "_ready"}, 128'(rdy_o[s]), 128'(er));
      chk({tag, "_data"},  dat_o[s], ed);
   endtask

   initial begin
      // Frame up, M=4, free-running sink
      add(0,1,1,0,1,4,0,   0,0,1,'0);
      add(0,1,0,1,1,4,1,   0,0,1,'0);
      add(0,1,0,1,1,4,2,   0,0,1,'0);
      add(0,1,0,1,1,4,3,   0,0,1,'0);
      add(0,1,0,1,1,4,4,   0,0,1,'0);
      add(0,1,0,0,1,4,0,   1,1,1,fr(1,2,3,4,0,0,0,0));
      add(0,1,0,0,1,4,0,   0,0,1,fr(1,2,3,4,0,0,0,0));
      // Frame down, M=4
      add(1,0,1,0,1,4,0,   0,0,1,'0);
      add(1,1,0,1,1,4,10,  0,0,1,'0);
      add(1,1,0,1,1,4,20,  0,0,1,'0);
      add(1,1,0,1,1,4,30,  0,0,1,'0);
      add(1,1,0,1,1,4,40,  0,0,1,'0);
      add(1,1,0,0,1,4,0,   1,1,1,fr(40,30,20,10,0,0,0,0));
      add(1,1,0,0,1,4,0,   0,0,1,fr(40,30,20,10,0,0,0,0));
      // Phase 2 discards two samples, M=3
      add(2,0,1,0,1,3,0,   0,0,1,'0);
      add(2,1,0,1,1,3,5,   0,0,1,'0);
      add(2,1,0,1,1,3,6,   0,0,1,'0);
      add(2,1,0,1,1,3,7,   0,0,1,'0);
      add(2,1,0,1,1,3,8,   0,0,1,'0);
      add(2,1,0,1,1,3,9,   0,0,1,'0);
      add(2,1,0,0,1,3,0,   1,1,1,fr(7,8,9,0,0,0,0,0));
      add(2,1,0,0,1,3,0,   0,0,1,fr(7,8,9,0,0,0,0,0));
      // Backpressure, M=2: last lane stalls until the sink drains
      add(0,0,1,0,0,2,0,   0,0,1,'0);
      add(0,1,0,1,0,2,11,  0,0,1,'0);
      add(0,1,0,1,0,2,12,  0,0,1,'0);
      add(0,1,0,1,0,2,13,  1,1,1,fr(11,12,0,0,0,0,0,0));
      add(0,1,0,1,0,2,14,  1,0,0,fr(11,12,0,0,0,0,0,0));
      add(0,1,0,1,0,2,14,  1,0,0,fr(11,12,0,0,0,0,0,0));
      add(0,1,0,1,1,2,14,  1,0,1,fr(11,12,0,0,0,0,0,0));
      add(0,1,0,0,1,2,0,   1,1,1,fr(13,14,0,0,0,0,0,0));
      add(0,1,0,0,1,2,0,   0,0,1,fr(13,14,0,0,0,0,0,0));
      // M change mid-frame takes effect next frame; M=0 clamps to 2
      add(0,0,1,0,1,4,0,   0,0,1,'0);
      add(0,1,0,1,1,4,21,  0,0,1,'0);
      add(0,1,0,1,1,4,22,  0,0,1,'0);
      add(0,1,0,1,1,2,23,  0,0,1,'0);
      add(0,1,0,1,1,2,24,  0,0,1,'0);
      add(0,1,0,1,1,2,25,  1,1,1,fr(21,22,23,24,0,0,0,0));
      add(0,1,0,1,1,2,26,  0,0,1,fr(21,22,23,24,0,0,0,0));
      add(0,1,0,1,1,0,27,  1,1,1,fr(25,26,0,0,0,0,0,0));
      add(0,1,0,1,1,0,28,  0,0,1,fr(25,26,0,0,0,0,0,0));
      add(0,1,0,0,1,0,0,   1,1,1,fr(27,28,0,0,0,0,0,0));

      #12;
      chk_out("reset", 0, 0, 0, 1, '0);
      rst_an = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         clr = tbl[i].clr; vld = tbl[i].vld; rdy = tbl[i].rdy;
         decim = tbl[i].decim; din = tbl[i].din;
         #1;
         if (tbl[i].chk)
            chk_out($sformatf("row%0d", i), tbl[i].sel, tbl[i].ev, tbl[i].ec, tbl[i].er, tbl[i].ed);
      end

`ifdef PPD_COMMUTATOR_STATUS_EN
      chk("frame_cnt_3", 128'(fcnt_o[0]), 128'd3);
      chk("cfg_err_set", 128'(err_o[0]),  128'd1);
`endif

      // Clear mid-frame while a frame is held
      step(1,0,0,4,0);
      step(0,1,0,4,31); step(0,1,0,4,32); step(0,1,0,4,33); step(0,1,0,4,34);
      step(0,1,0,4,35);
      chk_out("held", 0, 1, 1, 1, fr(31,32,33,34,0,0,0,0));
      step(0,1,0,4,36); step(0,1,0,4,37);
      step(1,0,0,4,0);
      step(0,1,1,4,41);
      chk_out("clr", 0, 0, 0, 1, '0);
      step(0,1,1,4,42); step(0,1,1,4,43); step(0,1,1,4,44);
      step(0,0,1,4,0);
      chk_out("fresh", 0, 1, 1, 1, fr(41,42,43,44,0,0,0,0));
`ifdef PPD_COMMUTATOR_STATUS_EN
      chk("frame_cnt_1", 128'(fcnt_o[0]), 128'd1);
      chk("cfg_err_clr", 128'(err_o[0]),  128'd0);
`endif

      // Async reset during a stall
      step(0,1,0,2,51); step(0,1,0,2,52);
      step(0,1,0,2,53);
      chk_out("pre_stall", 0, 1, 1, 1, fr(51,52,0,0,0,0,0,0));
      step(0,1,0,2,54);
      chk_out("stall", 0, 1, 0, 0, fr(51,52,0,0,0,0,0,0));
      #2 rst_an = 1'b0;
      #1;
      chk_out("async_rst", 0, 0, 0, 1, '0);
`ifdef PPD_COMMUTATOR_STATUS_EN
      chk("frame_cnt_rst", 128'(fcnt_o[0]), 128'd0);
`endif
      vld = 1'b0;
      rst_an = 1'b1;
      step(0,1,1,2,61); step(0,1,1,2,62);
      step(0,0,1,2,0);
      chk_out("post_rst", 0, 1, 1, 1, fr(61,62,0,0,0,0,0,0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
